// File: rtl/ramp_transition.sv
// Per-channel slew-limited level translator: each channel ramps its output code
// toward VALUE0/VALUE1. Optional busy/done status ports with `RAMP_STATUS_EN.
module ramp_transition #(
  parameter int WIDTH     = 8,
  parameter int CH        = 2,
  parameter int VALUE0    = -64,
  parameter int VALUE1    = 63,
  parameter int RISE_STEP = 32,
  parameter int FALL_STEP = 48
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CH-1:0]       in,
  output logic [CH*WIDTH-1:0] out
`ifdef RAMP_STATUS_EN
  ,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done
`endif
);

  localparam int CODE_MIN = -(1 << (WIDTH - 1));
  localparam int CODE_MAX = (1 << (WIDTH - 1)) - 1;

  if (!(VALUE0 < VALUE1) || (RISE_STEP < 1) || (FALL_STEP < 1) || (CH < 1) ||
      (VALUE0 < CODE_MIN) || (VALUE1 > CODE_MAX)) begin : g_param_check
    $error("ramp_transition: illegal parameter combination");
  end

  // One extra bit of headroom so out +/- step never wraps before clamping.
  localparam logic signed [WIDTH:0]   V0_W   = VALUE0[WIDTH:0];
  localparam logic signed [WIDTH:0]   V1_W   = VALUE1[WIDTH:0];
  localparam logic signed [WIDTH:0]   RISE_W = RISE_STEP[WIDTH:0];
  localparam logic signed [WIDTH:0]   FALL_W = FALL_STEP[WIDTH:0];
  localparam logic signed [WIDTH-1:0] V0_N   = VALUE0[WIDTH-1:0];
  localparam logic signed [WIDTH-1:0] V1_N   = VALUE1[WIDTH-1:0];

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    RISING  = 2'd1,
    HIGH    = 2'd2,
    FALLING = 2'd3
  } state_t;

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_ch
    state_t                  state_reg, state_next;
    logic signed [WIDTH-1:0] out_reg, out_next;
    logic signed [WIDTH:0]   cur_ext, target_ext, sum_ext, diff_ext;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_reg <= LOW;
        out_reg   <= V0_N;
      end else begin
        state_reg <= state_next;
        out_reg   <= out_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      out_next   = out_reg;
      cur_ext    = {out_reg[WIDTH-1], out_reg};
      target_ext = in[gi] ? V1_W : V0_W;
      sum_ext    = cur_ext + RISE_W;
      diff_ext   = cur_ext - FALL_W;
      if (en) begin
        if (cur_ext < target_ext) begin
          if (sum_ext >= V1_W) begin
            out_next   = V1_N;
            state_next = HIGH;
          end else begin
            out_next   = sum_ext[WIDTH-1:0];
            state_next = RISING;
          end
        end else if (cur_ext > target_ext) begin
          if (diff_ext <= V0_W) begin
            out_next   = V0_N;
            state_next = LOW;
          end else begin
            out_next   = diff_ext[WIDTH-1:0];
            state_next = FALLING;
          end
        end
      end
    end

    assign out[gi*WIDTH +: WIDTH] = out_reg;

`ifdef RAMP_STATUS_EN
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b0;
      end else begin
        busy_reg <= busy_next;
        done_reg <= done_next;
      end
    end

    // Status follows the state transition; frozen along with it while en is low.
    always_comb begin
      busy_next = busy_reg;
      done_next = done_reg;
      if (en) begin
        busy_next = (state_next == RISING) || (state_next == FALLING);
        done_next = ((state_reg == RISING) || (state_reg == FALLING)) &&
                    ((state_next == LOW) || (state_next == HIGH));
      end
    end

    assign busy[gi] = busy_reg;
    assign done[gi] = done_reg;
`endif
  end

endmodule

// File: tb/tb_ramp_transition.sv
// Randomized self-checking bench for ramp_transition against an integer-valued
// reference model of the ramp rules, plus directed sequences with fixed codes.
module tb_ramp_transition;

  localparam int WIDTH     = 8;
  localparam int CH        = 2;
  localparam int VALUE0    = -64;
  localparam int VALUE1    = 63;
  localparam int RISE_STEP = 32;
  localparam int FALL_STEP = 48;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                en = 1'b0;
  logic [CH-1:0]       in = '0;
  logic [CH*WIDTH-1:0] out;
`ifdef RAMP_STATUS_EN
  logic [CH-1:0]       busy;
  logic [CH-1:0]       done;
`endif

  int checks = 0;
  int errors = 0;

  int m_val  [CH];
  int m_busy [CH];
  int m_done [CH];

  ramp_transition #(
    .WIDTH(WIDTH), .CH(CH), .VALUE0(VALUE0), .VALUE1(VALUE1),
    .RISE_STEP(RISE_STEP), .FALL_STEP(FALL_STEP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .in(in),
    .out(out)
`ifdef RAMP_STATUS_EN
    ,
    .busy(busy),
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ch_out(input int k);
    logic signed [WIDTH-1:0] v;
    v = out[k*WIDTH +: WIDTH];
    return int'(v);
  endfunction

  function automatic int interior(input int v);
    return ((v > VALUE0) && (v < VALUE1)) ? 1 : 0;
  endfunction

  // Drive one cycle, advance the model on the same edge, compare #1 later.
  task automatic step(input logic r, input logic e, input logic [CH-1:0] i, input string tag);
    int prev, tgt;
    rst_n = r;
    en    = e;
    in    = i;
    @(posedge clk);
    for (int k = 0; k < CH; k++) begin
      if (!r) begin
        m_val[k] = VALUE0; m_busy[k] = 0; m_done[k] = 0;
      end else if (e) begin
        prev = m_val[k];
        tgt  = i[k] ? VALUE1 : VALUE0;
        if (prev < tgt)      m_val[k] = (prev + RISE_STEP > VALUE1) ? VALUE1 : prev + RISE_STEP;
        else if (prev > tgt) m_val[k] = (prev - FALL_STEP < VALUE0) ? VALUE0 : prev - FALL_STEP;
        m_busy[k] = interior(m_val[k]);
        m_done[k] = (interior(prev) == 1 && interior(m_val[k]) == 0) ? 1 : 0;
      end
    end
    #1;
    for (int k = 0; k < CH; k++) begin
      check($sformatf("%s out%0d", tag, k), ch_out(k), m_val[k]);
`ifdef RAMP_STATUS_EN
      check($sformatf("%s busy%0d", tag, k), int'(busy[k]), m_busy[k]);
      check($sformatf("%s done%0d", tag, k), int'(done[k]), m_done[k]);
`endif
    end
  endtask

  task automatic expect_seq(input logic [CH-1:0] i, input int n, input int exp_q[$], input string tag);
    for (int s = 0; s < n; s++) begin
      step(1'b1, 1'b1, i, tag);
      check($sformatf("%s fixed%0d", tag, s), ch_out(0), exp_q[s]);
    end
  endtask

  initial begin
    logic [CH-1:0] cur_in;
    int frozen;
    for (int k = 0; k < CH; k++) begin
      m_val[k] = VALUE0; m_busy[k] = 0; m_done[k] = 0;
    end

    step(1'b0, 1'b0, 2'b00, "reset");
    step(1'b0, 1'b1, 2'b11, "reset_prio");
    check("reset fixed", ch_out(1), -64);
    step(1'b1, 1'b1, 2'b00, "idle");
    step(1'b1, 1'b1, 2'b00, "idle");

    expect_seq(2'b01, 5, '{-32, 0, 32, 63, 63}, "rise");
    expect_seq(2'b00, 4, '{15, -33, -64, -64}, "fall");
    expect_seq(2'b01, 2, '{-32, 0}, "rev_up");
    expect_seq(2'b00, 3, '{-48, -64, -64}, "rev_dn");

    // Freeze mid-ramp, then resume.
    step(1'b1, 1'b1, 2'b01, "frz_pre");
    frozen = ch_out(0);
    for (int s = 0; s < 3; s++) begin
      step(1'b1, 1'b0, 2'b01, "frz");
      check("frz fixed", ch_out(0), frozen);
    end
    step(1'b1, 1'b1, 2'b01, "resume");
    check("resume fixed", ch_out(0), frozen + RISE_STEP);
    step(1'b1, 1'b1, 2'b01, "pre_rst");
    step(1'b0, 1'b1, 2'b01, "mid_rst");
    check("mid_rst fixed", ch_out(0), -64);

    // Lockstep, then channel 1 alone.
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b1, 2'b11, "lock");
      check("lock fixed", ch_out(1), ch_out(0));
    end
    for (int s = 0; s < 4; s++) begin
      step(1'b1, 1'b1, (s % 2 == 0) ? 2'b01 : 2'b11, "ch1tog");
      check("ch1tog fixed", ch_out(0), 63);
    end

    cur_in = 2'b00;
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < CH; k++)
        if ($urandom_range(0, 4) == 0) cur_in[k] = ~cur_in[k];
      step(($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1,
           ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1, cur_in, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramp_transition.md
RAMP_TRANSITION -- requirements
Module: ramp_transition

Interface
REQ-001 SHALL have parameter WIDTH, default 8, output code width per channel in two's complement.
REQ-002 SHALL have parameter CH, default 2, number of independent channels.
REQ-003 SHALL have parameter VALUE0, default -64, signed output level for logic 0.
REQ-004 SHALL have parameter VALUE1, default 63, signed output level for logic 1.
REQ-005 SHALL have parameter RISE_STEP, default 32, code increment per cycle while rising.
REQ-006 SHALL have parameter FALL_STEP, default 48, code decrement per cycle while falling.
REQ-007 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port en  input  1  ramp enable; low holds all channels.
REQ-010 SHALL have port in  input  CH  per-channel digital level; bit k drives channel k.
REQ-011 SHALL have port out  output  CH*WIDTH  ramped codes, registered; channel k at bits [k*WIDTH +: WIDTH].
REQ-012 SHALL have, only with RAMP_STATUS_EN defined, port busy  output  CH  channel k is in RISING or FALLING.
REQ-013 SHALL have, only with RAMP_STATUS_EN defined, port done  output  CH  one-cycle pulse when channel k reaches its target.

Function
REQ-014 SHALL keep one four-state FSM per channel: LOW, RISING, HIGH, FALLING.
REQ-015 SHALL compute target_k = VALUE1 if in[k] else VALUE0, sampling in[k] at every clk edge with en high.
REQ-016 SHALL, when en high and out_k < target_k, update out_k to min(out_k + RISE_STEP, VALUE1), with state RISING, or HIGH once equal to VALUE1.
REQ-017 SHALL, when en high and out_k > target_k, update out_k to max(out_k - FALL_STEP, VALUE0), with state FALLING, or LOW once equal to VALUE0.
REQ-018 SHALL produce the first changed out_k on the clk edge that samples the new in[k] level (1-cycle latency).
REQ-019 SHALL evaluate step and clamp in WIDTH+1-bit signed arithmetic, so no intermediate wrap-around occurs.
REQ-020 SHALL, on in[k] reversal mid-ramp, reverse direction at the next edge starting from the current out_k, without first completing the old ramp.
REQ-021 SHALL hold out, FSM states and any status outputs unchanged while en is low; a later en high resumes from the held value.
REQ-022 SHALL leave out_k and state unchanged when out_k equals target_k (LOW or HIGH).
REQ-023 SHALL operate channels fully independently; simultaneous events on several channels SHALL not interact.
REQ-024 SHALL reject elaboration unless VALUE0 < VALUE1, RISE_STEP >= 1, FALL_STEP >= 1, CH >= 1, and both values fit in signed WIDTH bits.

Reset
REQ-025 SHALL, on a clk edge with rst_n low, set every out_k to VALUE0 and every FSM to LOW, discarding any ramp in progress.
REQ-026 SHALL, with RAMP_STATUS_EN defined, reset busy and done to all-zero.
REQ-027 SHALL let rst_n take priority over en and in.

Configuration
REQ-028 SHALL, with macro RAMP_STATUS_EN defined, include busy (registered, equal to state RISING or FALLING) and done (registered, high one cycle on the edge where state enters LOW or HIGH from a ramp state).
REQ-029 SHALL, without RAMP_STATUS_EN, omit the busy and done ports and their logic entirely, with out behaviour identical in both builds.

Verification (defaults, CH=2)
REQ-030 SHALL cover: reset, then in=2'b00, en=1 -> both channels hold -64, state LOW; with status, busy=0 and done=0.
REQ-031 SHALL cover: in[0] 0->1 -> out_0 gives -32, 0, 32, 63 on successive edges, then holds 63; done[0] pulses on the 63 edge.
REQ-032 SHALL cover: from 63, in[0] 1->0 -> out_0 gives 15, -33, -64, then holds -64.
REQ-033 SHALL cover: in[0] 0->1, after out_0 reaches 0 set in[0]=0 -> next outputs -48, -64; no done pulse at reversal, done pulse on reaching -64.
REQ-034 SHALL cover: ramp in progress, en low for 3 cycles -> out_0 frozen; after en high, the ramp continues from the frozen value. The same stimulus with rst_n low mid-ramp -> out_0=-64 on the next edge.
REQ-035 SHALL cover: in=2'b11 in one cycle -> both channels ramp identically and in lockstep; toggling only in[1] leaves channel 0 unaffected.
